// File: rtl/bindemux.sv
// One-entry registered 1:2 demultiplexer with valid/ready handshakes on both sides.
// Optional per-channel transfer counters (cnt0/cnt1) are built when BINDEMUX_COUNT_EN is defined.
module bindemux #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out0_valid,
  output logic                  out1_valid,
  input  logic                  out0_ready,
  input  logic                  out1_ready
`ifdef BINDEMUX_COUNT_EN
  ,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] hold_data_reg;
  logic                  hold_sel_reg;
  logic                  hold_valid;
  logic                  sel_ready;
  logic                  in_xfer;
  logic                  load;
  logic [1:0]            out_ready;
  logic [1:0]            out_valid;

  assign out_ready  = {out1_ready, out0_ready};
  assign hold_valid = (state_reg == FULL);
  // Only the channel the held word is routed to can free the slot.
  assign sel_ready  = out_ready[hold_sel_reg];
  assign in_ready   = !hold_valid || sel_ready;
  assign in_xfer    = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign out_valid[gi] = hold_valid && (hold_sel_reg == 1'(gi));
    end
  endgenerate

  assign out0_valid = out_valid[0];
  assign out1_valid = out_valid[1];
  assign out0_data  = hold_data_reg;
  assign out1_data  = hold_data_reg;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        // A simultaneous drain and refill keeps the slot full for back-to-back flow.
        if (in_xfer) begin
          load = 1'b1;
        end else if (sel_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      hold_data_reg <= '0;
      hold_sel_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        hold_data_reg <= in_data;
        hold_sel_reg  <= in_sel;
      end
    end
  end

`ifdef BINDEMUX_COUNT_EN
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (out_valid[gi] && out_ready[gi]) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign cnt0 = g_cnt[0].cnt_reg;
  assign cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_bindemux.sv
// Bench for bindemux: directed scenarios plus a random run, all checked against a queue-based model.
// Counter checks are compiled in when BINDEMUX_COUNT_EN is defined.
module tb_bindemux;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready, out1_ready;
`ifdef BINDEMUX_COUNT_EN
  logic [15:0]   cnt0, cnt1;
`endif

  bindemux #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready)
`ifdef BINDEMUX_COUNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: words accepted but not yet delivered, in acceptance order.
  logic [DW:0]   q[$];
  logic [DW-1:0] last_data;
  int            delivered[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_data    = '0;
    delivered[0] = 0;
    delivered[1] = 0;
  endtask

  // Called just after a falling edge; drives inputs, checks outputs, advances one cycle.
  task automatic step(input logic iv, input logic sel, input logic [DW-1:0] d,
                      input logic r0, input logic r1);
    logic exp_ready, exp_v0, exp_v1, hsel;
    in_valid = iv; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    hsel      = (q.size() != 0) ? q[0][DW] : 1'b0;
    exp_v0    = (q.size() != 0) && !hsel;
    exp_v1    = (q.size() != 0) && hsel;
    exp_ready = (q.size() == 0) || (hsel ? r1 : r0);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out0_valid", 32'(out0_valid), 32'(exp_v0));
    check("out1_valid", 32'(out1_valid), 32'(exp_v1));
    check("out0_data", 32'(out0_data), 32'(last_data));
    check("out1_data", 32'(out1_data), 32'(last_data));
    check("one_hot", 32'(out0_valid & out1_valid), 32'd0);
`ifdef BINDEMUX_COUNT_EN
    check("cnt0", 32'(cnt0), 32'(delivered[0] % 65536));
    check("cnt1", 32'(cnt1), 32'(delivered[1] % 65536));
`endif
    if (q.size() != 0 && (hsel ? r1 : r0)) begin
      void'(q.pop_front());
      delivered[hsel]++;
    end
    if (iv && exp_ready) begin
      q.push_back({sel, d});
      last_data = d;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int d1;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_v0", 32'(out0_valid), 32'd0);
    check("rst_v1", 32'(out1_valid), 32'd0);
    check("rst_d0", 32'(out0_data), 32'd0);
    check("rst_d1", 32'(out1_data), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Single word on channel 0, accepted on the first edge after reset release.
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    check("a5_v0", 32'(out0_valid), 32'd1);
    check("a5_d0", 32'(out0_data), 32'hA5);
    check("a5_v1", 32'(out1_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("a5_empty_v0", 32'(out0_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Channel-1 stall with the other channel ready, including a blocked upstream offer.
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    d1 = delivered[1];
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_d1", 32'(out1_data), 32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("stall_once", 32'(delivered[1] - d1), 32'd1);
    check("stall_empty_v1", 32'(out1_valid), 32'd0);

    // Back-to-back stream with alternating destinations.
    d1 = delivered[0] + delivered[1];
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'(i % 2), 8'(i), 1'b1, 1'b1);
      check("stream_v", 32'(out0_valid | out1_valid), 32'd1);
      check("stream_d", 32'(out0_data), 32'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("stream_count", 32'(delivered[0] + delivered[1] - d1), 32'd16);

    // Reset while holding a channel-1 word must clear outputs without a clock edge.
    step(1'b1, 1'b1, 8'h5E, 1'b0, 1'b0);
    check("pre_rst_v1", 32'(out1_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_v1", 32'(out1_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_d0", 32'(out0_data), 32'd0);
    check("async_d1", 32'(out1_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("drain_q", 32'(q.size()), 32'd0);

`ifdef BINDEMUX_COUNT_EN
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("wrap_cnt0", 32'(cnt0), 32'd1);
    check("wrap_cnt1", 32'(cnt1), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bindemux.md
BINDEMUX -- requirements
Module: bindemux

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the data path in bits; the block SHALL accept any value >= 1.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_data  input  DATA_WIDTH  upstream payload.
REQ-005 in_sel  input  1  destination of the upstream word (0 -> channel 0, 1 -> channel 1).
REQ-006 in_valid  input  1  upstream word and in_sel are valid.
REQ-007 in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 out0_data, out1_data  output  DATA_WIDTH each  held payload, driven on both channels.
REQ-009 out0_valid, out1_valid  output  1 each  held word is destined for that channel.
REQ-010 out0_ready, out1_ready  input  1 each  downstream accepts on that channel.

Function
REQ-011 The block SHALL be a one-entry registered 1:2 demultiplexer with the states EMPTY and FULL; the state is the hold_valid flag, the payload is hold_data, and the destination is hold_sel.
REQ-012 An upstream transfer SHALL occur when in_valid && in_ready at the rising edge; a channel-k transfer SHALL occur when outk_valid && outk_ready at the rising edge.
REQ-013 out0_valid SHALL equal hold_valid && !hold_sel, out1_valid SHALL equal hold_valid && hold_sel, and at most one of them SHALL be high in any cycle.
REQ-014 out0_data and out1_data SHALL both equal hold_data in every cycle, independent of valid.
REQ-015 in_ready SHALL equal !hold_valid || (the selected channel's outk_ready), combinationally; it SHALL NOT depend on in_valid or in_sel.
REQ-016 EMPTY -> FULL on an upstream transfer, capturing in_data and in_sel.
REQ-017 FULL -> EMPTY on a channel transfer with no upstream transfer in the same cycle.
REQ-018 FULL -> FULL on a simultaneous channel transfer and upstream transfer; the new word and sel SHALL be captured, so sustained throughput is one word per cycle.
REQ-019 FULL with the selected outk_ready low SHALL hold hold_data and hold_sel stable, and in_ready SHALL be 0.
REQ-020 The ready of the non-selected channel SHALL have no effect on state or on in_ready.
REQ-021 Latency from upstream transfer to outk_valid SHALL be exactly 1 cycle.
REQ-022 Words SHALL leave in acceptance order; none SHALL be dropped, duplicated or misrouted.

Reset
REQ-023 While rst is high: hold_valid, hold_sel and hold_data SHALL be 0, so out0_valid = out1_valid = 0, both data outputs = 0, and in_ready = 1.
REQ-024 Asserting rst mid-operation SHALL discard a held word immediately, with no handshake required.
REQ-025 The first upstream transfer SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 When macro BINDEMUX_COUNT_EN is defined, the block SHALL add outputs cnt0 and cnt1 (16 bits each), which count channel-0 and channel-1 transfers respectively.
REQ-027 Each counter SHALL increment by 1 per transfer on its channel, wrap from 0xFFFF to 0x0000, and reset to 0 asynchronously with rst.
REQ-028 When BINDEMUX_COUNT_EN is undefined, cnt0, cnt1 and their logic SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-029 Apply rst mid-stream with FULL, hold_sel = 1 -> out1_valid drops to 0 without a clock edge, in_ready = 1, and the data outputs = 0.
REQ-030 Send in_data = 0xA5, in_sel = 0 with out0_ready = 1 -> next cycle out0_valid = 1, out0_data = 0xA5, out1_valid = 0; then EMPTY.
REQ-031 FULL with sel = 1, out1_ready = 0 and out0_ready = 1 for 5 cycles -> in_ready = 0 and hold_data stable; raise out1_ready -> word delivered once on channel 1.
REQ-032 Stream 0x01..0x10 with alternating sel and both readies high -> one word per cycle, in order, each on the correct channel, with no bubbles.
REQ-033 Drive random in_valid, in_sel and out readies for 10k cycles against a scoreboard -> no loss, no duplication, no misrouting, and out0_valid && out1_valid never both high.
REQ-034 With BINDEMUX_COUNT_EN defined, 65537 channel-0 transfers -> cnt0 = 1 and cnt1 = 0.
